// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Arbitrates the single register-file write port between the WB stage and the
// long-latency unit (mul/div). LLU results wait in a small FIFO; a busy
// scoreboard tells the hazard unit which registers still have an LLU write
// pending. When the FIFO fills, or its head has been refused for too long, the
// pipeline is stalled until the FIFO has been emptied.
// Optional statistics counters are enabled by defining WB_ARB_STATS_EN.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        W_reg_write_enable,
  input  logic [4:0]  W_rd,
  input  logic [31:0] W_wb_data,
  input  logic        llu_issue,
  input  logic [4:0]  llu_issue_rd,
  input  logic        llu_valid,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_o,
  output logic [31:0] busy_vec
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] stat_stall_cnt,
  output logic [31:0] stat_llu_wr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t        state, state_next;
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic          pipe_req, push, pop, fifo_empty;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [31:0]   busy_next;

  assign pipe_req   = W_reg_write_enable && (W_rd != 5'd0);
  // Readiness looks only at the occupancy, so a full FIFO never accepts even if it pops this cycle.
  assign llu_ready  = (count != FULL_CNT);
  // A result for x0 is acknowledged but never stored.
  assign push       = llu_valid && llu_ready && (llu_rd != 5'd0);
  assign fifo_empty = (count == '0);
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Port grant, pop decision, next occupancy, starvation counter and next state.
  always_comb begin
    pop        = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    wait_next  = '0;
    state_next = state;
    case (state)
      NORMAL: begin
        if (pipe_req) begin
          rf_we    = 1'b1;
          rf_waddr = W_rd;
          rf_wdata = W_wb_data;
          if (!fifo_empty) wait_next = wait_cnt + WW'(1);
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = head_rd;
          rf_wdata = head_data;
        end
      end
      DRAIN: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = head_rd;
          rf_wdata = head_data;
        end
      end
      default: state_next = NORMAL;
    endcase
    count_next = count + CW'(push) - CW'(pop);
    case (state)
      NORMAL:  if ((count_next == FULL_CNT) || (wait_next == WAIT_LIM)) state_next = DRAIN;
      DRAIN:   if (count_next == '0) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  // Scoreboard update: the LLU write to the register file clears, a new issue sets and wins a tie.
  always_comb begin
    busy_next = busy_vec;
    if (pop && (head_rd != 5'd0)) busy_next[head_rd] = 1'b0;
    if (llu_issue && (llu_issue_rd != 5'd0)) busy_next[llu_issue_rd] = 1'b1;
  end

  // FSM, FIFO bookkeeping, scoreboard and the registered stall output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NORMAL;
      stall_o  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      busy_vec <= 32'd0;
    end else begin
      state    <= state_next;
      stall_o  <= (state_next == DRAIN);
      count    <= count_next;
      wait_cnt <= wait_next;
      busy_vec <= busy_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // FIFO storage needs no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= llu_rd;
      fifo_data[wr_ptr] <= llu_data;
    end
  end

`ifdef WB_ARB_STATS_EN
  // Saturating counts of stalled cycles and of LLU writes into the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cnt  <= 32'd0;
      stat_llu_wr_cnt <= 32'd0;
    end else begin
      if (stall_o && (stat_stall_cnt != 32'hFFFF_FFFF)) stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (pop && (stat_llu_wr_cnt != 32'hFFFF_FFFF)) stat_llu_wr_cnt <= stat_llu_wr_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Directed bench for wb_port_arbiter. Expected LLU writes are queued when the
// result is presented and popped when the register-file write is due.
// Statistics outputs are checked when WB_ARB_STATS_EN is defined.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        W_reg_write_enable;
  logic [4:0]  W_rd;
  logic [31:0] W_wb_data;
  logic        llu_issue;
  logic [4:0]  llu_issue_rd;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_o;
  logic [31:0] busy_vec;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [31:0] stat_llu_wr_cnt;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .W_reg_write_enable (W_reg_write_enable),
    .W_rd               (W_rd),
    .W_wb_data          (W_wb_data),
    .llu_issue          (llu_issue),
    .llu_issue_rd       (llu_issue_rd),
    .llu_valid          (llu_valid),
    .llu_rd             (llu_rd),
    .llu_data           (llu_data),
    .llu_ready          (llu_ready),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .stall_o            (stall_o),
    .busy_vec           (busy_vec)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_stall_cnt     (stat_stall_cnt),
    .stat_llu_wr_cnt    (stat_llu_wr_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                input logic iss, input logic [4:0] iss_rd,
                                input logic vld, input logic [4:0] lrd, input logic [31:0] ldata);
    wr_t e;
    @(negedge clk);
    W_reg_write_enable = we;
    W_rd               = rd;
    W_wb_data          = data;
    llu_issue          = iss;
    llu_issue_rd       = iss_rd;
    llu_valid          = vld;
    llu_rd             = lrd;
    llu_data           = ldata;
    if (vld && (lrd != 5'd0)) begin
      e.rd   = lrd;
      e.data = ldata;
      sb_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_output(input string tag, input logic exp_we, input logic from_llu,
                              input logic [4:0] exp_addr, input logic [31:0] exp_data,
                              input logic exp_stall, input logic exp_ready);
    wr_t e;
    logic [4:0]  a;
    logic [31:0] d;
    a = exp_addr;
    d = exp_data;
    check({tag, ".rf_we"}, rf_we, exp_we);
    if (exp_we) begin
      if (from_llu) begin
        check({tag, ".sb_nonempty"}, (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          a = e.rd;
          d = e.data;
        end
      end
      check({tag, ".rf_waddr"}, rf_waddr, a);
      check({tag, ".rf_wdata"}, rf_wdata, d);
    end
    check({tag, ".stall_o"}, stall_o, exp_stall);
    check({tag, ".llu_ready"}, llu_ready, exp_ready);
  endtask

  initial begin
    $display("[TB] start");
    rst                = 1'b1;
    W_reg_write_enable = 1'b0;
    W_rd               = 5'd0;
    W_wb_data          = 32'd0;
    llu_issue          = 1'b0;
    llu_issue_rd       = 5'd0;
    llu_valid          = 1'b1;
    llu_rd             = 5'd3;
    llu_data           = 32'hDEAD_0003;
    repeat (2) @(posedge clk);

    // Reset held two edges with an LLU result pending: nothing may be stored.
    idle();
    rst = 1'b0;
    check_output("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    check("reset.busy", busy_vec, 32'd0);

    // Pipe-only writes, including the x0 suppression.
    apply_stimulus(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_output("pipe", 1'b1, 1'b0, 5'd5, 32'hA5, 1'b0, 1'b1);
    apply_stimulus(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_output("pipe_x0", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // LLU on an idle port: issue, result, write one cycle later, busy cleared.
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    check("issue.busy_reg", busy_vec, 32'd0);
    idle();
    check("issue.busy_set", busy_vec, 32'h0000_0080);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234);
    check_output("llu_accept", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    idle();
    check_output("llu_write", 1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b1);
    check("llu_write.busy", busy_vec, 32'h0000_0080);
    idle();
    check_output("llu_after", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    check("llu_after.busy", busy_vec, 32'd0);

    // Starvation: one queued entry refused four times, then a one-cycle drain.
    apply_stimulus(1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 1'b1, 5'd10, 32'hBEEF);
    check_output("starve0", 1'b1, 1'b0, 5'd1, 32'h100, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b1, 5'd2, 32'h200 + k, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      check_output($sformatf("starve%0d", k), 1'b1, 1'b0, 5'd2, 32'h200 + k, 1'b0, 1'b1);
    end
    apply_stimulus(1'b1, 5'd2, 32'h2FF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_output("starve_drain", 1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 1'b1);
    apply_stimulus(1'b1, 5'd2, 32'h2FF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_output("starve_resume", 1'b1, 1'b0, 5'd2, 32'h2FF, 1'b0, 1'b1);

    // Full FIFO: two results behind a busy pipe, then a two-cycle drain.
    apply_stimulus(1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 1'b1, 5'd11, 32'hB1);
    check_output("full1", 1'b1, 1'b0, 5'd3, 32'h300, 1'b0, 1'b1);
    apply_stimulus(1'b1, 5'd3, 32'h301, 1'b0, 5'd0, 1'b1, 5'd12, 32'hB2);
    check_output("full2", 1'b1, 1'b0, 5'd3, 32'h301, 1'b0, 1'b1);
    apply_stimulus(1'b1, 5'd3, 32'h301, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_output("drain1", 1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'd3, 32'h301, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_output("drain2", 1'b1, 1'b1, 5'd0, 32'd0, 1'b1, 1'b1);
    apply_stimulus(1'b1, 5'd3, 32'h301, 1'b0, 5'd0, 1'b1, 5'd0, 32'hDEAD);
    check_output("drain_done", 1'b1, 1'b0, 5'd3, 32'h301, 1'b0, 1'b1);
    idle();
    check_output("llu_x0_dropped", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Issue/clear race on x9: the new issue must survive the write of the old result.
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hB9);
    check("race.busy_set", busy_vec, 32'h0000_0200);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    check_output("race_write", 1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b1);
    idle();
    check("race.busy_kept", busy_vec, 32'h0000_0200);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hC9);
    idle();
    check_output("race_write2", 1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b1);
    idle();
    check("race.busy_clear", busy_vec, 32'd0);
    check("sb.empty", sb_q.size(), 32'd0);

`ifdef WB_ARB_STATS_EN
    check("stat_stall_cnt", stat_stall_cnt, 32'd3);
    check("stat_llu_wr_cnt", stat_llu_wr_cnt, 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
